// File: rtl/sa_mm_ctrl.sv
// sa_mm_ctrl: job-level tile sequencer driving the matrix-vector manager and PE array.
// Optional feature macro: SA_CTRL_PERF_EN builds the stalled-cycle counter behind O_STALL_CNT.
module sa_mm_ctrl #(
  parameter int unsigned X_R       = 16,
  parameter int unsigned W_C       = 16,
  parameter int unsigned DRAIN_CYC = X_R + W_C - 1
) (
  input  logic        I_CLK,
  input  logic        I_ASYN_RST,
  input  logic        I_REQ_VLD,
  output logic        O_REQ_RDY,
  input  logic [7:0]  I_M_DIM,
  input  logic [3:0]  I_ROW_TILES,
  input  logic [3:0]  I_COL_TILES,
  input  logic        I_MGR_OVER,
  input  logic        I_STALL,
  input  logic        I_TILE_RDY,
  output logic        O_MGR_START,
  output logic        O_PE_CLR,
  output logic        O_PE_SHIFT,
  output logic [3:0]  O_ROW_IDX,
  output logic [3:0]  O_COL_IDX,
  output logic        O_TILE_VLD,
  output logic        O_DONE,
  output logic        O_BUSY,
  output logic [15:0] O_STALL_CNT
);

  localparam int unsigned TILE_W = 4;
  localparam int unsigned DRN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [TILE_W-1:0]   r_row_tiles;
  logic [TILE_W-1:0]   r_col_tiles;
  logic [TILE_W-1:0]   r_row_idx;
  logic [TILE_W-1:0]   r_col_idx;
  logic [DRN_W-1:0]    r_drain_cnt;

  logic w_zero_job;
  logic w_last_col;
  logic w_last_row;
  logic w_last_tile;
  logic w_drain_last;
  logic w_accept;
  logic w_drain_clr;
  logic w_drain_inc;
  logic w_tile_adv;

  // A job with any zero extent completes without touching the manager.
  assign w_zero_job   = (I_M_DIM == 8'd0) || (I_ROW_TILES == 4'd0) || (I_COL_TILES == 4'd0);
  assign w_last_col   = (r_col_idx == (r_col_tiles - TILE_W'(1)));
  assign w_last_row   = (r_row_idx == (r_row_tiles - TILE_W'(1)));
  assign w_last_tile  = w_last_row && w_last_col;
  assign w_drain_last = (r_drain_cnt == DRN_W'(DRAIN_CYC - 1));

  assign O_ROW_IDX = r_row_idx;
  assign O_COL_IDX = r_col_idx;

  // State register
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next_state = r_state;
    O_REQ_RDY    = 1'b0;
    O_BUSY       = 1'b1;
    O_MGR_START  = 1'b0;
    O_PE_CLR     = 1'b0;
    O_PE_SHIFT   = 1'b0;
    O_TILE_VLD   = 1'b0;
    O_DONE       = 1'b0;
    w_accept     = 1'b0;
    w_drain_clr  = 1'b0;
    w_drain_inc  = 1'b0;
    w_tile_adv   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        O_REQ_RDY = 1'b1;
        O_BUSY    = 1'b0;
        if (I_REQ_VLD) begin
          w_accept     = 1'b1;
          w_next_state = w_zero_job ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        O_MGR_START  = 1'b1;
        O_PE_CLR     = 1'b1;
        w_next_state = ST_FEED;
      end
      ST_FEED: begin
        // The over-detect cycle issues no shift and moves on regardless of stall.
        if (I_MGR_OVER) begin
          w_drain_clr  = 1'b1;
          w_next_state = ST_DRAIN;
        end else begin
          O_PE_SHIFT = !I_STALL;
        end
      end
      ST_DRAIN: begin
        O_PE_SHIFT = !I_STALL;
        if (!I_STALL) begin
          w_drain_inc = 1'b1;
          if (w_drain_last) begin
            w_next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        O_TILE_VLD = 1'b1;
        if (I_TILE_RDY) begin
          if (w_last_tile) begin
            w_next_state = ST_DONE;
          end else begin
            w_tile_adv   = 1'b1;
            w_next_state = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        O_DONE       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Job fields, row-major tile walk and drain counter
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      r_row_tiles <= '0;
      r_col_tiles <= '0;
      r_row_idx   <= '0;
      r_col_idx   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_row_tiles <= I_ROW_TILES;
        r_col_tiles <= I_COL_TILES;
        r_row_idx   <= '0;
        r_col_idx   <= '0;
      end else if (w_tile_adv) begin
        if (w_last_col) begin
          r_col_idx <= '0;
          r_row_idx <= r_row_idx + TILE_W'(1);
        end else begin
          r_col_idx <= r_col_idx + TILE_W'(1);
        end
      end
      if (w_drain_clr) begin
        r_drain_cnt <= '0;
      end else if (w_drain_inc) begin
        r_drain_cnt <= r_drain_cnt + DRN_W'(1);
      end
    end
  end

`ifdef SA_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall_evt;

  assign w_stall_evt = I_STALL && ((r_state == ST_FEED) || (r_state == ST_DRAIN));

  // Saturating stalled-cycle counter, restarted by each accepted job.
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign O_STALL_CNT = r_stall_cnt;
`else
  assign O_STALL_CNT = CNT_W'(0);
`endif

endmodule
